fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small in-order instruction buffer between the instruction fetch stage and the decode stage of the pipelined RV32I core.
- Captures {instruction, PC, halt} words from fetch and presents them to decode with a valid/ready handshake.
- Absorbs decode stalls and back-pressures fetch when full.
- Discards all buffered entries on a branch/jump redirect (flush) coming from the execute stage.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of the instruction and PC fields.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  redirect from execute (same event that loads branch_pc into fetch); drops all entries.
- in_valid  input  1  fetch presents a word this cycle.
- in_instruction  input  XLEN  fetched instruction word.
- in_pc  input  XLEN  PC of in_instruction.
- in_halt  input  1  fetch flagged the opcode as unsupported (halt).
- in_ready  output  1  queue accepts a word this cycle; fetch must hold its PC while low.
- out_valid  output  1  head entry valid.
- out_instruction  output  XLEN  head instruction.
- out_pc  output  XLEN  head PC.
- out_halt  output  1  head halt flag.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries.
  - rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - count tracks occupancy, range 0..DEPTH.
- Push and pop:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Output status:
  - in_ready = (count != DEPTH) && (state == RUN).
  - in_ready does not depend combinationally on out_ready, so a full queue does not accept a word in the cycle it pops.
  - out_valid = (count != 0).
  - out_* are driven from the head entry; their values are don't-care when out_valid = 0.
- Latency (base build): a word pushed in cycle N is visible at the output in cycle N+1.
- Occupancy update:
  - Simultaneous push and pop: count unchanged, both pointers advance, FIFO order preserved.
  - Push only: count+1.
  - Pop only: count-1.
  - Neither: hold.
- State machine (2 states):
  - RUN: normal operation.
  - HALTED: entered on the cycle a word with in_halt = 1 is pushed. That word is stored normally. in_ready is held at 0, so no further words are accepted. Entries already queued, including the halt word, still drain to decode.
  - HALTED -> RUN: only on flush or rst.
- Flush (highest priority after rst):
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0, state = RUN.
  - Any push or pop in the flush cycle is ignored; the pushed word is dropped and decode must treat an out_valid seen in that cycle as squashed.
- Reset (rst = 1 at a rising edge, including mid-operation): same effect as flush. After reset: count = 0, out_valid = 0, in_ready = 1, state = RUN.
- Storage contents are not reset.
- Boundary conditions:
  - Push while full: impossible, because in_ready = 0; in_valid is ignored.
  - Pop while empty: impossible, because out_valid = 0; out_ready is ignored.
  - Flush while empty or while HALTED: returns to RUN with count = 0.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- When defined, a zero-latency bypass is active when count == 0:
  - out_valid = in_valid && in_ready.
  - out_instruction, out_pc and out_halt take the corresponding in_* values combinationally.
  - If out_ready is also 1, the word is consumed without being written; count stays 0, pointers unchanged.
  - If out_ready is 0, the word is written as a normal push.
  - A bypassed word with in_halt = 1 still moves the state to HALTED.
  - Flush still suppresses the bypass.
- When not defined: no combinational path from in_* to out_*; minimum latency is 1 cycle.

Test Plan:
- Reset: rst = 1 for 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, in_ready = 1 after release; no word retained.
- Fill/drain: out_ready = 0; push PCs 0x0, 0x4, 0x8, 0xC -> count = 4, in_ready = 0; a 5th word (PC 0x10) is not accepted. Then out_ready = 1 -> outputs 0x0, 0x4, 0x8, 0xC on consecutive cycles, count reaches 0.
- Concurrent: count = 2; push and pop in the same cycle for 6 cycles with PCs 0x20 to 0x34 -> count stays 2, output PC order strictly sequential, pointers wrap with no loss.
- Flush: count = 3 and in_valid = 1 with PC 0x40 in the flush cycle -> next cycle count = 0, out_valid = 0; 0x40 is never output. The next push, PC 0x80 from branch_pc, is output first.
- Halt: push 0x100 (in_halt = 0) then 0x104 (in_halt = 1) -> in_ready = 0 from the next cycle; decode receives 0x100, then 0x104 with out_halt = 1; in_ready stays 0 for 10+ cycles until flush, then returns to 1.
- Bypass (FETCH_QUEUE_BYPASS_EN defined): empty queue, out_ready = 1, in_valid = 1 with PC 0x200 -> out_valid = 1 and out_pc = 0x200 in the same cycle, count stays 0. Without the macro, out_pc = 0x200 appears one cycle later.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// master = environment side (fetch drives in_*, decode drives out_ready); slave = the queue.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  // Both sides use valid/ready: a word transfers on a rising edge where valid && ready,
  // the producer holds its payload stable while valid && !ready, and ready never
  // depends combinationally on the same port's valid.
  logic            in_valid;
  logic [XLEN-1:0] in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            in_halt;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_instruction;
  logic [XLEN-1:0] out_pc;
  logic            out_halt;
  logic            out_ready;

  modport master (
    output in_valid, in_instruction, in_pc, in_halt, out_ready,
    input  in_ready, out_valid, out_instruction, out_pc, out_halt
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, in_halt, out_ready,
    output in_ready, out_valid, out_instruction, out_pc, out_halt
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch-to-decode buffer with halt lock-out and redirect flush.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_queue_if.slave             q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic            mem_halt  [DEPTH];

  logic push, pop, byp_take, wr_en, rd_en;

  // Flush/reset squash any handshake seen in the same cycle.
  assign push = q.in_valid  && q.in_ready  && !flush;
  assign pop  = q.out_valid && q.out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_take = (count == '0) && push && q.out_ready;
`else
  assign byp_take = 1'b0;
`endif

  // A bypassed word is consumed straight from the input and never touches storage.
  assign wr_en = push && !byp_take;
  assign rd_en = pop  && !byp_take;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush)                                     state_d = RUN;
    else if (state_q == RUN && push && q.in_halt)  state_d = HALTED;
  end

  // State-derived outputs
  always_comb begin
    q.in_ready = (count != FULL) && (state_q == RUN);
    dbg_state  = (state_q == HALTED);
  end

  // Head presentation
  always_comb begin
    q.out_valid       = (count != '0);
    q.out_instruction = mem_instr[rd_ptr];
    q.out_pc          = mem_pc[rd_ptr];
    q.out_halt        = mem_halt[rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (count == '0) begin
      q.out_valid       = q.in_valid && q.in_ready && !flush;
      q.out_instruction = q.in_instruction;
      q.out_pc          = q.in_pc;
      q.out_halt        = q.in_halt;
    end
`endif
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_instr[wr_ptr] <= q.in_instruction;
      mem_pc[wr_ptr]    <= q.in_pc;
      mem_halt[wr_ptr]  <= q.in_halt;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases plus a scoreboard of accepted words.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int W     = 2 * XLEN + 1;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH):0] count;
  logic dbg_state;

  fetch_queue_if #(.XLEN(XLEN)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .q         (fq.slave),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return (pc * 32'd3) ^ 32'h0000_0013;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic halt, input logic rdy);
    fq.in_valid       = v;
    fq.in_pc          = pc;
    fq.in_instruction = instr_of(pc);
    fq.in_halt        = halt;
    fq.out_ready      = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 || flush === 1'b1) begin
      exp_q.delete();
    end else begin
      if (fq.in_valid === 1'b1 && fq.in_ready === 1'b1)
        exp_q.push_back({fq.in_halt, fq.in_instruction, fq.in_pc});
      if (fq.out_valid === 1'b1 && fq.out_ready === 1'b1) begin
        if (exp_q.size() == 0)
          chk("sb_underflow", W'(1), W'(0));
        else
          chk("sb_word", {fq.out_halt, fq.out_instruction, fq.out_pc}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b1, 32'hF00, 1'b0, 1'b0);

    // Reset held 2 cycles with in_valid high
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_count", W'(count), W'(0));
    chk("rst_out_valid", W'(fq.out_valid), W'(0));
    chk("rst_in_ready", W'(fq.in_ready), W'(1));
    chk("rst_state", W'(dbg_state), W'(0));
    next_cycle();

    // Fill to full, attempt a 5th, then drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      @(negedge clk);
      chk("fill_in_ready", W'(fq.in_ready), W'(1));
      next_cycle();
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", W'(count), W'(4));
    chk("full_in_ready", W'(fq.in_ready), W'(0));
    next_cycle();
    @(negedge clk);
    chk("full_hold_count", W'(count), W'(4));
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", W'(fq.out_valid), W'(1));
      chk("drain_pc", W'(fq.out_pc), W'(i * 4));
      next_cycle();
    end
    @(negedge clk);
    chk("drain_count", W'(count), W'(0));
    chk("drain_out_valid", W'(fq.out_valid), W'(0));
    next_cycle();

    // Concurrent push/pop at occupancy 2, wrapping the pointers
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h1C, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(32'h20 + i * 4), 1'b0, 1'b1);
      @(negedge clk);
      chk("conc_count", W'(count), W'(2));
      chk("conc_pc", W'(fq.out_pc), W'(32'h18 + i * 4));
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("conc_empty", W'(count), W'(0));
    next_cycle();

    // Flush with three entries queued and a word offered in the flush cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h50 + i * 4), 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("pre_flush_count", W'(count), W'(3));
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", W'(count), W'(0));
    chk("flush_out_valid", W'(fq.out_valid), W'(0));
    next_cycle();
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("redirect_valid", W'(fq.out_valid), W'(1));
    chk("redirect_pc", W'(fq.out_pc), W'(32'h80));
    next_cycle();

    // Halt lock-out and recovery via flush
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h104, 1'b1, 1'b0);
    @(negedge clk);
    chk("halt_push_ready", W'(fq.in_ready), W'(1));
    next_cycle();
    drive(1'b1, 32'h108, 1'b0, 1'b1);
    @(negedge clk);
    chk("halted_in_ready", W'(fq.in_ready), W'(0));
    chk("halted_state", W'(dbg_state), W'(1));
    chk("halt_head0_pc", W'(fq.out_pc), W'(32'h100));
    chk("halt_head0_flag", W'(fq.out_halt), W'(0));
    next_cycle();
    @(negedge clk);
    chk("halt_head1_pc", W'(fq.out_pc), W'(32'h104));
    chk("halt_head1_flag", W'(fq.out_halt), W'(1));
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halted_hold_ready", W'(fq.in_ready), W'(0));
      chk("halted_drained", W'(fq.out_valid), W'(0));
      next_cycle();
    end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("unhalt_in_ready", W'(fq.in_ready), W'(1));
    chk("unhalt_state", W'(dbg_state), W'(0));
    next_cycle();

    // Empty queue, decode ready: bypass vs one-cycle latency
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_valid", W'(fq.out_valid), W'(1));
    chk("byp_same_pc", W'(fq.out_pc), W'(32'h200));
    chk("byp_same_count", W'(count), W'(0));
`else
    chk("nobyp_same_valid", W'(fq.out_valid), W'(0));
`endif
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_next_valid", W'(fq.out_valid), W'(0));
`else
    chk("nobyp_next_valid", W'(fq.out_valid), W'(1));
    chk("nobyp_next_pc", W'(fq.out_pc), W'(32'h200));
`endif
    next_cycle();
    @(negedge clk);
    chk("byp_final_count", W'(count), W'(0));
    next_cycle();

    // Mid-operation reset drops queued words
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_count", W'(count), W'(0));
    chk("midrst_out_valid", W'(fq.out_valid), W'(0));
    chk("midrst_in_ready", W'(fq.in_ready), W'(1));
    next_cycle();

    // ---------------- report ----------------
    @(negedge clk);
    chk("sb_empty", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
